frog_key_conditioner: RTL and testbench

- Sits between the USB keycode PIO export and the frog movers.
- Converts the raw 16-bit keycode level, sampled on Clk, into frame-aligned move strobes. Each strobe is held for exactly one frame, so each frog (clocked by the VGA vsync frame clock) sees exactly one step per event.
- Adds hold-to-repeat, latches the active-frog selection, and locks out movement while the game is frozen (win/lose).

---
 rtl/frogger_pkg.sv | 54 +++++
 rtl/frame_tick_sync.sv | 29 ++
 rtl/frog_key_conditioner.sv | 119 +++++++++++
 tb/tb_frog_key_conditioner.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/frogger_pkg.sv
`default_nettype none
// frogger_pkg: shared direction/state types and USB keycodes for the frog key path.
package frogger_pkg;

    typedef enum logic [2:0] {
        DIR_NONE,
        DIR_UP,
        DIR_DOWN,
        DIR_LEFT,
        DIR_RIGHT
    } dir_t;

    typedef enum logic [1:0] {
        IDLE,
        DELAY,
        REPEAT,
        LOCKOUT
    } kc_state_t;

    localparam logic [15:0] KC_UP    = 16'h0052;
    localparam logic [15:0] KC_DOWN  = 16'h0051;
    localparam logic [15:0] KC_LEFT  = 16'h0050;
    localparam logic [15:0] KC_RIGHT = 16'h004F;
    localparam logic [15:0] KC_FROG1 = 16'h0059;
    localparam logic [15:0] KC_FROG2 = 16'h005A;
    localparam logic [15:0] KC_FROG3 = 16'h005B;

    function automatic dir_t decode_dir(input logic [15:0] kc);
        dir_t d;
        case (kc)
            KC_UP:    d = DIR_UP;
            KC_DOWN:  d = DIR_DOWN;
            KC_LEFT:  d = DIR_LEFT;
            KC_RIGHT: d = DIR_RIGHT;
            default:  d = DIR_NONE;
        endcase
        return d;
    endfunction

    // Strobe vector order is {up, down, left, right}.
    function automatic logic [3:0] dir_onehot(input dir_t d);
        logic [3:0] v;
        case (d)
            DIR_UP:    v = 4'b1000;
            DIR_DOWN:  v = 4'b0100;
            DIR_LEFT:  v = 4'b0010;
            DIR_RIGHT: v = 4'b0001;
            default:   v = 4'b0000;
        endcase
        return v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/frame_tick_sync.sv
`default_nettype none
// frame_tick_sync: 2-flop synchroniser plus delay flop; one-clock pulse per rising edge.
module frame_tick_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic async_level,
    output logic tick
);

    logic meta;
    logic sync;
    logic delayed;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta    <= 1'b0;
            sync    <= 1'b0;
            delayed <= 1'b0;
        end else begin
            meta    <= async_level;
            sync    <= meta;
            delayed <= sync;
        end
    end

    assign tick = sync & ~delayed;

endmodule
`default_nettype wire

// File: rtl/frog_key_conditioner.sv
`default_nettype none
// frog_key_conditioner: turns the raw keycode level into frame-aligned, auto-repeating
// move strobes, latches the frog selection and locks out movement while frozen.
module frog_key_conditioner
    import frogger_pkg::*;
#(
    parameter int unsigned REPEAT_DELAY = 20,
    parameter int unsigned REPEAT_RATE  = 8
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic [15:0] keycode,
    input  logic        frame_clk,
    input  logic        freeze,
    output logic        up,
    output logic        down,
    output logic        left,
    output logic        right,
    output logic [1:0]  frog_sel,
    output logic        frame_tick
);

    localparam logic [5:0] DELAY_LIMIT = 6'(REPEAT_DELAY);
    localparam logic [5:0] RATE_LIMIT  = 6'(REPEAT_RATE);

    logic [15:0] kc_q;
    dir_t        dir;
    kc_state_t   state, next_state;
    dir_t        held_dir, next_held;
    logic [5:0]  cnt, next_cnt;
    logic [3:0]  strobe, next_strobe;

    frame_tick_sync u_tick (
        .clk         (Clk),
        .rst_n       (Reset_n),
        .async_level (frame_clk),
        .tick        (frame_tick)
    );

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            kc_q     <= '0;
            frog_sel <= 2'd0;
        end else begin
            kc_q <= keycode;
            case (kc_q)
                KC_FROG1: frog_sel <= 2'd1;
                KC_FROG2: frog_sel <= 2'd2;
                KC_FROG3: frog_sel <= 2'd3;
                default:  frog_sel <= frog_sel;
            endcase
        end
    end

    assign dir = decode_dir(kc_q);

    // Any direct key change restarts the delay as a fresh press.
    always_comb begin
        next_state  = state;
        next_held   = held_dir;
        next_cnt    = cnt;
        next_strobe = 4'b0000;
        if (freeze) begin
            next_state = LOCKOUT;
            next_cnt   = 6'd0;
        end else begin
            case (state)
                LOCKOUT: begin
                    if (dir == DIR_NONE) begin
                        next_state = IDLE;
                    end
                end
                IDLE: begin
                    if (dir != DIR_NONE) begin
                        next_state  = DELAY;
                        next_held   = dir;
                        next_cnt    = 6'd1;
                        next_strobe = dir_onehot(dir);
                    end
                end
                DELAY, REPEAT: begin
                    if (dir == DIR_NONE) begin
                        next_state = IDLE;
                        next_cnt   = 6'd0;
                    end else if (dir != held_dir) begin
                        next_state  = DELAY;
                        next_held   = dir;
                        next_cnt    = 6'd1;
                        next_strobe = dir_onehot(dir);
                    end else if (cnt == ((state == DELAY) ? DELAY_LIMIT : RATE_LIMIT)) begin
                        next_state  = REPEAT;
                        next_cnt    = 6'd1;
                        next_strobe = dir_onehot(dir);
                    end else begin
                        next_cnt = cnt + 6'd1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state    <= IDLE;
            held_dir <= DIR_NONE;
            cnt      <= 6'd0;
            strobe   <= 4'b0000;
        end else if (frame_tick) begin
            state    <= next_state;
            held_dir <= next_held;
            cnt      <= next_cnt;
            strobe   <= next_strobe;
        end
    end

    assign {up, down, left, right} = strobe;

endmodule
`default_nettype wire

// File: tb/tb_frog_key_conditioner.sv
`default_nettype none
// tb_frog_key_conditioner: randomized and directed frame-level checks against a press-age model.
module tb_frog_key_conditioner;

    localparam int D = 20;
    localparam int R = 8;

    logic        Clk = 1'b0;
    logic        Reset_n = 1'b0;
    logic [15:0] keycode = 16'h0000;
    logic        frame_clk = 1'b0;
    logic        freeze = 1'b0;
    logic        up, down, left, right;
    logic [1:0]  frog_sel;
    logic        frame_tick;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: locked flag, held direction (0 = none, 1..4 = U/D/L/R), press age.
    int         m_locked;
    int         m_held;
    int         m_age;
    logic [3:0] m_strobe;
    logic [1:0] m_sel;

    frog_key_conditioner #(.REPEAT_DELAY(D), .REPEAT_RATE(R)) dut (
        .Clk        (Clk),
        .Reset_n    (Reset_n),
        .keycode    (keycode),
        .frame_clk  (frame_clk),
        .freeze     (freeze),
        .up         (up),
        .down       (down),
        .left       (left),
        .right      (right),
        .frog_sel   (frog_sel),
        .frame_tick (frame_tick)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int kdir(input logic [15:0] k);
        case (k)
            16'h0052: return 1;
            16'h0051: return 2;
            16'h0050: return 3;
            16'h004F: return 4;
            default:  return 0;
        endcase
    endfunction

    function automatic logic [3:0] dir_bits(input int d);
        logic [3:0] v;
        v = 4'b1000;
        return (d == 0) ? 4'b0000 : (v >> (d - 1));
    endfunction

    task automatic model_reset();
        m_locked = 0;
        m_held   = 0;
        m_age    = 0;
        m_strobe = 4'b0000;
        m_sel    = 2'd0;
    endtask

    task automatic model_tick(input logic [15:0] k, input logic frz);
        int d;
        d = kdir(k);
        m_strobe = 4'b0000;
        if (frz) begin
            m_locked = 1;
            m_held   = 0;
        end else if (m_locked != 0) begin
            if (d == 0) m_locked = 0;
        end else if (d == 0) begin
            m_held = 0;
        end else if (d != m_held) begin
            m_held   = d;
            m_age    = 0;
            m_strobe = dir_bits(d);
        end else begin
            m_age++;
            if (m_age == D || (m_age > D && ((m_age - D) % R) == 0))
                m_strobe = dir_bits(d);
        end
    endtask

    // One frame: 10 Clk high, then 5 Clk low; tick must be one Clk wide, seen at the 2nd negedge.
    task automatic run_frame();
        int hi_cnt;
        int first;
        hi_cnt = 0;
        first  = -1;
        frame_clk = 1'b1;
        for (int k = 1; k <= 15; k++) begin
            if (k == 11) frame_clk = 1'b0;
            @(negedge Clk);
            if (frame_tick) begin
                hi_cnt++;
                if (first < 0) first = k;
            end
        end
        check("tick_count", hi_cnt, 1);
        check("tick_pos", first, 2);
    endtask

    task automatic do_frame(input logic [15:0] k, input logic frz);
        keycode = k;
        freeze  = frz;
        if (k == 16'h0059) m_sel = 2'd1;
        if (k == 16'h005A) m_sel = 2'd2;
        if (k == 16'h005B) m_sel = 2'd3;
        repeat (5) @(negedge Clk);
        model_tick(k, frz);
        run_frame();
        check("strobe", {up, down, left, right}, m_strobe);
        check("frog_sel", frog_sel, m_sel);
    endtask

    task automatic glitch();
        logic [15:0] saved;
        int          ticks;
        saved   = keycode;
        ticks   = 0;
        keycode = 16'h004F;
        for (int k = 0; k < 100; k++) begin
            @(negedge Clk);
            if (frame_tick) ticks++;
        end
        keycode = saved;
        check("glitch_ticks", ticks, 0);
        check("glitch_strobe", {up, down, left, right}, m_strobe);
    endtask

    initial begin
        logic [15:0] k;
        logic        frz;
        int          guard;

        model_reset();
        repeat (3) @(negedge Clk);
        check("rst_strobe", {up, down, left, right}, 0);
        check("rst_frog_sel", frog_sel, 0);
        check("rst_tick", frame_tick, 0);
        Reset_n = 1'b1;
        repeat (2) @(negedge Clk);

        // Long hold of up: first press, delay, then repeats.
        for (int f = 0; f < 40; f++) do_frame(16'h0052, 1'b0);
        do_frame(16'h0000, 1'b0);
        // Direct change left -> right.
        for (int f = 0; f < 5; f++) do_frame(16'h0050, 1'b0);
        for (int f = 0; f < 26; f++) do_frame(16'h004F, 1'b0);

        // Frog select latches within two Clk and holds through keycode 0.
        keycode = 16'h005A;
        m_sel   = 2'd2;
        repeat (2) @(negedge Clk);
        check("frog_sel_fast", frog_sel, 2);
        do_frame(16'h005A, 1'b0);
        do_frame(16'h0000, 1'b0);
        do_frame(16'h0051, 1'b0);

        // Freeze with key held, unfreeze still held, release, then press.
        do_frame(16'h0000, 1'b0);
        for (int f = 0; f < 10; f++) do_frame(16'h0052, 1'b1);
        for (int f = 0; f < 5; f++) do_frame(16'h0052, 1'b0);
        do_frame(16'h0000, 1'b0);
        for (int f = 0; f < 3; f++) do_frame(16'h0052, 1'b0);

        glitch();
        do_frame(16'h0000, 1'b0);
        glitch();

        // Randomized traffic.
        k   = 16'h0000;
        frz = 1'b0;
        for (int f = 0; f < 300; f++) begin
            if ($urandom_range(0, 99) >= 90) begin
                case ($urandom_range(0, 8))
                    0: k = 16'h0000;
                    1: k = 16'h0052;
                    2: k = 16'h0051;
                    3: k = 16'h0050;
                    4: k = 16'h004F;
                    5: k = 16'h0059;
                    6: k = 16'h005A;
                    7: k = 16'h005B;
                    default: k = 16'($urandom_range(1, 16'hFFFF));
                endcase
            end
            if ($urandom_range(0, 99) < 4) frz = ~frz;
            do_frame(k, frz);
        end

        // Reset while repeating with a strobe up.
        do_frame(16'h0000, 1'b0);
        do_frame(16'h0059, 1'b0);
        for (int f = 0; f < 22; f++) do_frame(16'h0052, 1'b0);
        guard = 0;
        while (m_strobe == 4'b0000 && guard < 20) begin
            do_frame(16'h0052, 1'b0);
            guard++;
        end
        check("repeat_strobe_seen", {up, down, left, right}, 4'b1000);
        #2 Reset_n = 1'b0;
        #1;
        check("async_rst_strobe", {up, down, left, right}, 0);
        check("async_rst_frog_sel", frog_sel, 0);
        model_reset();
        @(negedge Clk);
        Reset_n = 1'b1;
        do_frame(16'h0052, 1'b0);
        do_frame(16'h0052, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
